// File: rtl/mlp_frame_sequencer.sv
// rtl/mlp_frame_sequencer.sv - stream front end for the 8-feature MLP classifier
// Packs features into the classifier word, waits for it to settle, returns the class and counts results.
module mlp_frame_sequencer #(
  parameter int N_FEAT = 8,
  parameter int FEAT_W = 4,
  parameter int CLS_W  = 2,
  parameter int N_CLS  = 3,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FEAT_W-1:0]        s_feat,
  input  logic                     s_last,
  output logic [N_FEAT*FEAT_W-1:0] clf_inp,
  input  logic [CLS_W-1:0]         clf_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CLS_W-1:0]         m_class,
  output logic                     frame_err,
  input  logic                     stat_clr,
  output logic [N_CLS*CNT_W-1:0]   cls_count
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

  typedef enum logic [1:0] {ST_COLLECT, ST_SETTLE, ST_OUTPUT} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q;
  logic [3:0]                scnt_q;
  logic [N_FEAT*FEAT_W-1:0]  inp_q;
  logic [CLS_W-1:0]          class_q;
  logic                      err_q;
  logic [CNT_W-1:0]          cnt_q [N_CLS];

  logic accept, last_slot, settle_done, handshake;

  always_comb begin
    accept      = (state_q == ST_COLLECT) && s_valid;
    last_slot   = (idx_q == IDX_W'(N_FEAT - 1));
    settle_done = (state_q == ST_SETTLE) && (scnt_q == 4'(SETTLE - 1));
    handshake   = (state_q == ST_OUTPUT) && m_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (accept && last_slot) state_d = ST_SETTLE;
      ST_SETTLE:  if (settle_done) state_d = ST_OUTPUT;
      ST_OUTPUT:  if (handshake) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_COLLECT;
    else        state_q <= state_d;
  end

  // Frame assembly; an early s_last abandons the partial frame but keeps its written slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      inp_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        inp_q[idx_q*FEAT_W +: FEAT_W] <= s_feat;
        if (last_slot) begin
          idx_q <= '0;
          err_q <= !s_last;
        end else if (s_last) begin
          idx_q <= '0;
          err_q <= 1'b1;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q  <= '0;
      class_q <= '0;
    end else if (settle_done) begin
      scnt_q  <= '0;
      class_q <= clf_out;
    end else if (state_q == ST_SETTLE) begin
      scnt_q  <= scnt_q + 4'd1;
    end
  end

  // Out-of-range classes match no counter, so they are returned but never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CLS; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < N_CLS; c++) begin
        if (stat_clr)
          cnt_q[c] <= '0;
        else if (handshake && (class_q == CLS_W'(c)) && (cnt_q[c] != {CNT_W{1'b1}}))
          cnt_q[c] <= cnt_q[c] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_CLS; g++) begin : g_cnt
    assign cls_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign s_ready   = (state_q == ST_COLLECT);
  assign m_valid   = (state_q == ST_OUTPUT);
  assign m_class   = class_q;
  assign clf_inp   = inp_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_mlp_frame_sequencer.sv
// tb/tb_mlp_frame_sequencer.sv - directed bench for mlp_frame_sequencer
// A small arithmetic classifier stands in for the MLP; a second instance uses 4-bit counters.
module tb_mlp_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [3:0]  s_feat = '0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b1;
  logic        stat_clr = 1'b0;
  logic        force_en = 1'b0;
  logic [1:0]  force_val = '0;

  logic        s_ready, m_valid, frame_err;
  logic [31:0] clf_inp;
  logic [1:0]  clf_out, m_class;
  logic [47:0] cls_count;

  logic        s_ready4, m_valid4, frame_err4;
  logic [31:0] clf_inp4;
  logic [1:0]  clf_out4, m_class4;
  logic [11:0] cls_count4;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt [3];

  always #5 clk = ~clk;

  // Stand-in classifier: (sum of features + 1) mod 3, so an all-zero frame yields class 1.
  function automatic logic [1:0] cls_model(input logic [31:0] w);
    int s = 1;
    for (int k = 0; k < 8; k++) s += int'(w[k*4 +: 4]);
    return 2'(s % 3);
  endfunction

  assign clf_out  = force_en ? force_val : cls_model(clf_inp);
  assign clf_out4 = force_en ? force_val : cls_model(clf_inp4);

  mlp_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_feat(s_feat),
    .s_last(s_last), .clf_inp(clf_inp), .clf_out(clf_out), .m_valid(m_valid),
    .m_ready(m_ready), .m_class(m_class), .frame_err(frame_err), .stat_clr(stat_clr),
    .cls_count(cls_count)
  );

  mlp_frame_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready4), .s_feat(s_feat),
    .s_last(s_last), .clf_inp(clf_inp4), .clf_out(clf_out4), .m_valid(m_valid4),
    .m_ready(m_ready), .m_class(m_class4), .frame_err(frame_err4), .stat_clr(stat_clr),
    .cls_count(cls_count4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] pack_cnt();
    return {exp_cnt[2], exp_cnt[1], exp_cnt[0]};
  endfunction

  task automatic clear_exp();
    for (int c = 0; c < 3; c++) exp_cnt[c] = '0;
  endtask

  task automatic send_feat(input logic [3:0] f, input logic last);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_feat = f; s_last = last;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_ready) check("send_timeout", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w, input logic with_last);
    for (int k = 0; k < 8; k++) send_feat(w[k*4 +: 4], with_last && (k == 7));
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < 30) begin @(negedge clk); n++; end
    check("valid_wait", m_valid, 1);
  endtask

  task automatic complete(input logic [1:0] exp);
    @(posedge clk); #1;
    if (exp < 2'd3) exp_cnt[exp]++;
    @(negedge clk);
  endtask

  task automatic do_frame(input string tag, input logic [31:0] w, input logic [1:0] exp);
    send_frame(w, 1'b1);
    wait_valid();
    check(tag, m_class, exp);
    complete(exp);
    check({tag, "_cnt"}, cls_count, pack_cnt());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {s_ready, m_valid, m_class, frame_err}, 5'b1_0_00_0);
    check({tag, "_inp"}, clf_inp, 0);
    check({tag, "_cnt"}, cls_count, 0);
  endtask

  initial begin
    logic        bad;
    logic [1:0]  held;
    logic [31:0] w;

    clear_exp();
    #1;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    do_frame("zero_frame", 32'h0, 2'd1);

    send_frame(32'h87654321, 1'b1);
    @(negedge clk);
    check("ord_inp", clf_inp, 32'h87654321);
    check("ord_c1", {s_ready, m_valid}, 2'b00);
    @(negedge clk);
    check("ord_c2", {s_ready, m_valid}, 2'b00);
    @(negedge clk);
    check("ord_c3", {s_ready, m_valid}, 2'b01);
    check("ord_class", m_class, 2'd1);
    complete(2'd1);
    check("ord_cnt", cls_count, pack_cnt());
    check("ord_ready", {s_ready, m_valid}, 2'b10);

    for (int r = 0; r < 6; r++) begin
      w = $urandom;
      do_frame("rand_frame", w, cls_model(w));
    end

    // Backpressure: class 2 held while the feature stream keeps pushing.
    m_ready = 1'b0;
    send_frame(32'h00000031, 1'b1);
    wait_valid();
    held = m_class;
    check("bp_class", held, 2'd2);
    bad = 1'b0;
    s_valid = 1'b1; s_feat = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!m_valid || m_class != held || s_ready || clf_inp != 32'h00000031) bad = 1'b1;
    end
    check("bp_stable", bad, 0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    complete(2'd2);
    check("bp_cnt", cls_count, pack_cnt());

    // Early s_last on the third feature.
    send_feat(4'h5, 1'b0);
    send_feat(4'h6, 1'b0);
    send_feat(4'h7, 1'b1);
    @(negedge clk);
    check("early_err", frame_err, 1);
    @(negedge clk);
    check("early_err_once", frame_err, 0);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_valid) bad = 1'b1;
    end
    check("early_no_result", bad, 0);
    do_frame("after_early", 32'h00000031, 2'd2);
    check("after_early_inp", clf_inp, 32'h00000031);

    // Full frame with no s_last.
    send_frame(32'h11111111, 1'b0);
    @(negedge clk);
    check("nolast_err", frame_err, 1);
    wait_valid();
    check("nolast_class", m_class, 2'd0);
    complete(2'd0);
    check("nolast_cnt", cls_count, pack_cnt());

    force_en = 1'b1; force_val = 2'd3;
    do_frame("class3", 32'h0, 2'd3);
    force_en = 1'b0;

    for (int i = 0; i < 20; i++) do_frame("sat_frame", 32'h00000002, 2'd0);
    check("sat_cnt4", cls_count4[3:0], 4'd15);

    m_ready = 1'b0;
    send_frame(32'h0, 1'b1);
    wait_valid();
    @(negedge clk);
    stat_clr = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    clear_exp();
    @(negedge clk);
    check("clr_cnt", cls_count, 0);
    check("clr_cnt4", cls_count4, 0);
    check("clr_state", {s_ready, m_valid}, 2'b10);

    do_frame("pre_rst", 32'h0, 2'd1);
    for (int k = 0; k < 5; k++) send_feat(4'(k + 9), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    clear_exp();
    check_reset_outputs("rst_mid_frame");
    @(negedge clk);
    rst_n = 1'b1;
    do_frame("post_rst1", 32'h87654321, 2'd1);
    check("post_rst1_inp", clf_inp, 32'h87654321);

    m_ready = 1'b0;
    send_frame(32'h00000031, 1'b1);
    wait_valid();
    rst_n = 1'b0;
    #1;
    clear_exp();
    check_reset_outputs("rst_mid_out");
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    do_frame("post_rst2", 32'h00000031, 2'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
